// File: rtl/ex_stage.sv
// Execute stage: ALU result for the forwarding bus, HI/LO registers and a
// radix-2 restoring divider that holds the pipeline while it iterates.
//
// state   | meaning
// IDLE    | no divide in flight; a DIV/DIVU starts here
// DIVZERO | divisor was zero; result forced to 0/0
// ON      | one shift-subtract iteration per cycle
// END     | sign-correct, write HI/LO, release the pipeline
module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        annul_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_SLTU = 8'h2B;
  localparam logic [7:0] OP_MFHI = 8'h10;
  localparam logic [7:0] OP_MFLO = 8'h12;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  localparam int CW = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} div_state_e;

  div_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        stall;
  logic        div_start;
  logic        a_neg, b_neg;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] result;

  assign div_start = ((aluop_i == OP_DIV) || (aluop_i == OP_DIVU)) && !annul_i;
  assign a_neg     = (aluop_i == OP_DIV) && reg1_i[31];
  assign b_neg     = (aluop_i == OP_DIV) && reg2_i[31];
  assign shifted   = {rem_q, quo_q[31]};
  assign diff      = shifted - {1'b0, dvs_q};

  // Divider state and HI/LO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Divider next state, iteration datapath and stall request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (div_start) begin
          stall   = 1'b1;
          quo_d   = a_neg ? (~reg1_i + 32'd1) : reg1_i;
          dvs_d   = b_neg ? (~reg2_i + 32'd1) : reg2_i;
          rem_d   = '0;
          cnt_d   = '0;
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          state_d = (reg2_i == 32'd0) ? S_DIVZERO : S_ON;
        end
      end
      S_DIVZERO: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          stall   = 1'b1;
          quo_d   = '0;
          rem_d   = '0;
          state_d = S_END;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          stall = 1'b1;
          // Restoring step: keep the difference only when it did not borrow.
          if (shifted >= {1'b0, dvs_q}) begin
            rem_d = diff[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = shifted[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DIV_CYCLES - 1)) begin
            state_d = S_END;
          end
        end
      end
      S_END: begin
        state_d = S_IDLE;
        if (!annul_i) begin
          hi_d = negr_q ? (~rem_q + 32'd1) : rem_q;
          lo_d = negq_q ? (~quo_q + 32'd1) : quo_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Single-cycle ALU result.
  always_comb begin
    result = '0;
    case (alusel_i)
      SEL_LOGIC: begin
        case (aluop_i)
          OP_OR:   result = reg1_i | reg2_i;
          OP_AND:  result = reg1_i & reg2_i;
          OP_XOR:  result = reg1_i ^ reg2_i;
          OP_NOR:  result = ~(reg1_i | reg2_i);
          default: result = '0;
        endcase
      end
      SEL_SHIFT: begin
        case (aluop_i)
          OP_SLL:  result = reg2_i << reg1_i[4:0];
          OP_SRL:  result = reg2_i >> reg1_i[4:0];
          OP_SRA:  result = $signed(reg2_i) >>> reg1_i[4:0];
          default: result = '0;
        endcase
      end
      SEL_MOVE: begin
        case (aluop_i)
          OP_MFHI: result = hi_q;
          OP_MFLO: result = lo_q;
          default: result = '0;
        endcase
      end
      SEL_ARITH: begin
        case (aluop_i)
          OP_ADDU: result = reg1_i + reg2_i;
          OP_SUBU: result = reg1_i - reg2_i;
          OP_SLT:  result = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
          OP_SLTU: result = {31'd0, reg1_i < reg2_i};
          default: result = '0;
        endcase
      end
      default: result = '0;
    endcase
  end

  // Forwarding bus; reset forces it quiet without waiting for a clock.
  always_comb begin
    wdata_o    = rst ? 32'd0 : result;
    wd_o       = rst ? 5'd0 : wd_i;
    wreg_o     = rst ? 1'b0 : (wreg_i && !stall);
    stallreq_o = rst ? 1'b0 : stall;
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule
